// File: rtl/y86_mem_arbiter_if.sv
// rtl/y86_mem_arbiter_if.sv - fetch/data request and memory beat bundle for the Y86 memory arbiter
interface y86_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_valid_o;
    logic              if_err_o;
    logic [79:0]       if_rdata_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [63:0]       dm_wdata_i;
    logic              dm_valid_o;
    logic              dm_err_o;
    logic [63:0]       dm_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [63:0]       mem_wdata_o;
    logic              mem_ack_i;
    logic [63:0]       mem_rdata_i;
    logic              F_stall_req_o;
    logic              M_stall_req_o;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        output if_valid_o, if_err_o, if_rdata_o, dm_valid_o, dm_err_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, F_stall_req_o, M_stall_req_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  if_valid_o, if_err_o, if_rdata_o, dm_valid_o, dm_err_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, F_stall_req_o, M_stall_req_o
    );
endinterface

// File: rtl/y86_mem_arbiter.sv
// rtl/y86_mem_arbiter.sv - shares one variable-latency memory between Y86 fetch and memory stages
module y86_mem_arbiter #(
    parameter int unsigned ADDR_W   = 64,
    parameter logic [63:0] MEM_SIZE = 64'h2000,
    parameter int unsigned TIMEOUT  = 15
) (
    input logic              clk_i,
    input logic              rst_i,
    y86_mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] IF_LIMIT = ADDR_W'(MEM_SIZE - 64'd10);
    localparam logic [ADDR_W-1:0] DM_LIMIT = ADDR_W'(MEM_SIZE - 64'd8);

    typedef enum logic [2:0] {IDLE, DM_WAIT, IF_BEAT0, IF_BEAT1, RESP} state_t;

    state_t            state;
    logic              prio_if;
    logic [CNT_W-1:0]  wait_cnt;
    logic [63:0]       beat0;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              if_valid, if_err, dm_valid, dm_err;
    logic [79:0]       if_rdata;
    logic [63:0]       dm_rdata;
    logic              win_if, if_bad, dm_bad, timed_out;

    // Fetch wins a contest only when it lost the previous one.
    assign win_if    = bus.if_req_i & (~bus.dm_req_i | prio_if);
    assign if_bad    = bus.if_addr_i > IF_LIMIT;
    assign dm_bad    = bus.dm_addr_i > DM_LIMIT;
    assign timed_out = ~bus.mem_ack_i & (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            prio_if   <= 1'b0;
            wait_cnt  <= '0;
            beat0     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            dm_valid  <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (bus.if_req_i && bus.dm_req_i) prio_if <= ~win_if;
                    if (win_if) begin
                        if (if_bad) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                            state    <= RESP;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= bus.if_addr_i;
                            state    <= IF_BEAT0;
                        end
                    end else if (bus.dm_req_i) begin
                        if (dm_bad) begin
                            dm_valid <= 1'b1;
                            dm_err   <= 1'b1;
                            dm_rdata <= '0;
                            state    <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= bus.dm_we_i;
                            mem_addr  <= bus.dm_addr_i;
                            mem_wdata <= bus.dm_wdata_i;
                            state     <= DM_WAIT;
                        end
                    end
                end
                DM_WAIT: begin
                    if (bus.mem_ack_i || timed_out) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        dm_valid <= 1'b1;
                        dm_err   <= ~bus.mem_ack_i;
                        dm_rdata <= (bus.mem_ack_i && !mem_we) ? bus.mem_rdata_i : 64'd0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                IF_BEAT0: begin
                    if (bus.mem_ack_i) begin
                        beat0    <= bus.mem_rdata_i;
                        mem_addr <= mem_addr + ADDR_W'(8);
                        wait_cnt <= '0;
                        state    <= IF_BEAT1;
                    end else if (timed_out) begin
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= '0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                IF_BEAT1: begin
                    if (bus.mem_ack_i || timed_out) begin
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        if_err   <= ~bus.mem_ack_i;
                        if_rdata <= bus.mem_ack_i ? {bus.mem_rdata_i[15:0], beat0} : 80'd0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if_valid <= 1'b0;
                    dm_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_o     = mem_req;
    assign bus.mem_we_o      = mem_we;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wdata_o   = mem_wdata;
    assign bus.if_valid_o    = if_valid;
    assign bus.if_err_o      = if_err;
    assign bus.if_rdata_o    = if_rdata;
    assign bus.dm_valid_o    = dm_valid;
    assign bus.dm_err_o      = dm_err;
    assign bus.dm_rdata_o    = dm_rdata;
    assign bus.F_stall_req_o = bus.if_req_i & ~if_valid;
    assign bus.M_stall_req_o = bus.dm_req_i & ~dm_valid;
endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb/tb_y86_mem_arbiter.sv - self-checking bench for y86_mem_arbiter
module tb_y86_mem_arbiter;
    localparam logic [63:0] SIZE = 64'h2000;
    localparam int          TO   = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y86_mem_arbiter_if #(.ADDR_W(64)) bus ();

    y86_mem_arbiter #(.ADDR_W(64), .MEM_SIZE(SIZE), .TIMEOUT(TO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [7:0]  mem [0:8191];
    int          lat = 0;
    int          wcnt = 0;
    bit          force_ack = 0;
    logic [63:0] acked_addr[$];
    int          n_pass = 0, n_total = 0;
    bit          prio_m = 0;
    logic [79:0] last_if_rdata;
    logic [63:0] last_dm_rdata;

    function automatic logic [79:0] rdn(input logic [63:0] a, input int n);
        logic [79:0] r = '0;
        for (int i = 0; i < n; i++)
            if (a + 64'(i) < SIZE) r[8*i +: 8] = mem[13'(a + 64'(i))];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Memory with a fixed per-beat ack latency; writes land on ack.
    always @(negedge clk) begin
        if (bus.mem_req_o) begin
            if (bus.mem_ack_i) wcnt = 0;
            if (wcnt == lat) begin
                logic [79:0] r;
                r = rdn(bus.mem_addr_o, 8);
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = r[63:0];
                if (bus.mem_we_o)
                    for (int i = 0; i < 8; i++)
                        if (bus.mem_addr_o + 64'(i) < SIZE)
                            mem[13'(bus.mem_addr_o + 64'(i))] = bus.mem_wdata_o[8*i +: 8];
                acked_addr.push_back(bus.mem_addr_o);
            end else begin
                bus.mem_ack_i   = 1'b0;
                bus.mem_rdata_i = {$urandom, $urandom};
                wcnt++;
            end
        end else begin
            bus.mem_ack_i   = force_ack;
            bus.mem_rdata_i = {$urandom, $urandom};
            wcnt = 0;
        end
    end

    task automatic run(input bit rif, input logic [63:0] aif, input bit rdm, input bit we,
                       input logic [63:0] adm, input logic [63:0] wd, input int l,
                       output int fc, output bit fi, output bit fe);
        int  cyc = 0, reqc = 0, eif, edm, ereq = 0;
        bit  pif = rif, pdm = rdm, bad_if, bad_dm, got = 0;
        bit  win_if = rif && (!rdm || prio_m);
        logic [79:0] r;
        if (rif && rdm) prio_m = !win_if;
        bad_if = aif > SIZE - 10;
        bad_dm = adm > SIZE - 8;
        eif = bad_if ? 1 : (l >= TO ? TO + 1 : 3 + 2 * l);
        edm = bad_dm ? 1 : (l >= TO ? TO + 1 : 2 + l);
        if (rif) ereq += bad_if ? 0 : (l >= TO ? TO : 2 * (l + 1));
        if (rdm) ereq += bad_dm ? 0 : (l >= TO ? TO : l + 1);
        if (rif && rdm) begin
            if (win_if) edm += eif + 1;
            else eif += edm + 1;
        end
        fc = 0; fi = 0; fe = 0;
        @(negedge clk); #1;
        lat = l;
        bus.if_req_i = rif; bus.if_addr_i = aif;
        bus.dm_req_i = rdm; bus.dm_we_i = we; bus.dm_addr_i = adm; bus.dm_wdata_i = wd;
        while ((pif || pdm) && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
            if (bus.mem_req_o) reqc++;
            if (pif) chk("f_stall", 80'(bus.F_stall_req_o), 80'(cyc != eif));
            if (pdm) chk("m_stall", 80'(bus.M_stall_req_o), 80'(cyc != edm));
            if (bus.if_valid_o) begin
                if (!pif) chk("if_spurious_valid", 1, 0);
                else begin
                    r = (bad_if || l >= TO) ? 80'd0 : rdn(aif, 10);
                    chk("if_valid_cycle", 80'(cyc), 80'(eif));
                    chk("if_err", 80'(bus.if_err_o), 80'(bad_if || l >= TO));
                    chk("if_rdata", bus.if_rdata_o, r);
                    last_if_rdata = bus.if_rdata_o;
                    if (!got) begin fc = cyc; fi = 1; fe = bus.if_err_o; got = 1; end
                    pif = 0; bus.if_req_i = 0;
                end
            end
            if (bus.dm_valid_o) begin
                if (!pdm) chk("dm_spurious_valid", 1, 0);
                else begin
                    r = (bad_dm || l >= TO || we) ? 80'd0 : rdn(adm, 8);
                    chk("dm_valid_cycle", 80'(cyc), 80'(edm));
                    chk("dm_err", 80'(bus.dm_err_o), 80'(bad_dm || l >= TO));
                    chk("dm_rdata", 80'(bus.dm_rdata_o), r);
                    last_dm_rdata = bus.dm_rdata_o;
                    if (!got) begin fc = cyc; fi = 0; fe = bus.dm_err_o; got = 1; end
                    pdm = 0; bus.dm_req_i = 0;
                end
            end
        end
        if (pif || pdm) chk("txn_cycle_budget", 1, 0);
        chk("mem_req_cycles", 80'(reqc), 80'(ereq));
    endtask

    typedef struct {
        bit rif; logic [63:0] aif; bit rdm; bit we; logic [63:0] adm; logic [63:0] wd;
        int lat; int exp_cyc; bit exp_if; bit exp_err;
    } vec_t;

    vec_t        tbl[9];
    int          fc;
    bit          fi, fe;
    logic [63:0] k;

    initial begin
        tbl[0] = '{0, 0,        1, 0, 64'h100,  0,       0,  2,  0, 0};
        tbl[1] = '{1, 64'h40,   0, 0, 0,        0,       0,  3,  1, 0};
        tbl[2] = '{1, 64'h1FF7, 0, 0, 0,        0,       0,  1,  1, 1};
        tbl[3] = '{1, 64'h1FF6, 0, 0, 0,        0,       0,  3,  1, 0};
        tbl[4] = '{0, 0,        1, 1, 64'h200,  64'h55,  20, 16, 0, 1};
        tbl[5] = '{0, 0,        1, 0, 64'h1FF8, 0,       1,  3,  0, 0};
        tbl[6] = '{0, 0,        1, 0, 64'h1FF9, 0,       0,  1,  0, 1};
        tbl[7] = '{1, 64'h80,   0, 0, 0,        0,       2,  7,  1, 0};
        tbl[8] = '{1, 64'h100,  0, 0, 0,        0,       30, 16, 1, 1};

        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.dm_req_i = 0; bus.dm_we_i = 0;
        bus.dm_addr_i = 0; bus.dm_wdata_i = 0; bus.mem_ack_i = 0; bus.mem_rdata_i = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_mem_req", 80'(bus.mem_req_o), 0);
        chk("reset_mem_addr", 80'(bus.mem_addr_o), 0);
        chk("reset_if_valid", 80'(bus.if_valid_o), 0);
        chk("reset_dm_valid", 80'(bus.dm_valid_o), 0);
        chk("reset_if_rdata", bus.if_rdata_o, 0);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].rif, tbl[i].aif, tbl[i].rdm, tbl[i].we, tbl[i].adm, tbl[i].wd,
                tbl[i].lat, fc, fi, fe);
            chk($sformatf("vec%0d_cycle", i), 80'(fc), 80'(tbl[i].exp_cyc));
            chk($sformatf("vec%0d_src", i), 80'(fi), 80'(tbl[i].exp_if));
            chk($sformatf("vec%0d_err", i), 80'(fe), 80'(tbl[i].exp_err));
        end

        // Acks arriving with no beat outstanding must be ignored.
        force_ack = 1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("late_ack_mem_req", 80'(bus.mem_req_o), 0);
            chk("late_ack_valid", 80'(bus.dm_valid_o | bus.if_valid_o), 0);
        end
        force_ack = 0;

        k = 64'h1122334455667788;
        for (int i = 0; i < 8; i++) mem[13'h100 + 13'(i)] = k[8*i +: 8];
        run(0, 0, 1, 0, 64'h100, 0, 0, fc, fi, fe);
        chk("dm_read_0x100_rdata", 80'(last_dm_rdata), 80'(64'h1122334455667788));

        k = 64'h0807060504030201;
        for (int i = 0; i < 8; i++) mem[13'h40 + 13'(i)] = k[8*i +: 8];
        mem[13'h48] = 8'h09; mem[13'h49] = 8'h0A; mem[13'h4A] = 8'hFF; mem[13'h4B] = 8'hFF;
        acked_addr.delete();
        run(1, 64'h40, 0, 0, 0, 0, 0, fc, fi, fe);
        chk("fetch_0x40_rdata", last_if_rdata, 80'h0A090807060504030201);
        chk("fetch_0x40_beats", 80'(acked_addr.size()), 2);
        if (acked_addr.size() == 2) begin
            chk("fetch_beat0_addr", 80'(acked_addr[0]), 80'h40);
            chk("fetch_beat1_addr", 80'(acked_addr[1]), 80'h48);
        end

        run(1, 64'h300, 1, 0, 64'h400, 0, 0, fc, fi, fe);
        chk("contest1_data_first", 80'(fi), 0);
        chk("contest1_cycle", 80'(fc), 2);
        run(1, 64'h300, 1, 0, 64'h400, 0, 0, fc, fi, fe);
        chk("contest2_fetch_first", 80'(fi), 1);
        chk("contest2_cycle", 80'(fc), 3);
        run(1, 64'h308, 1, 1, 64'h300, 64'hDEAD, 1, fc, fi, fe);
        chk("contest3_data_first", 80'(fi), 0);

        // Reset while the second fetch beat is outstanding.
        @(negedge clk); #1;
        lat = 3; bus.if_addr_i = 64'h200; bus.if_req_i = 1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
            chk("rst_no_early_valid", 80'(bus.if_valid_o), 0);
        end
        chk("rst_in_beat1_addr", 80'(bus.mem_addr_o), 80'h208);
        rst = 1;
        @(negedge clk); #1;
        rst = 0; bus.if_req_i = 0; prio_m = 0;
        chk("rst_mid_mem_req", 80'(bus.mem_req_o), 0);
        chk("rst_mid_mem_addr", 80'(bus.mem_addr_o), 0);
        chk("rst_mid_mem_wdata", 80'(bus.mem_wdata_o), 0);
        chk("rst_mid_if_err", 80'(bus.if_err_o), 0);
        chk("rst_mid_if_rdata", bus.if_rdata_o, 0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_mid_no_valid", 80'(bus.if_valid_o | bus.dm_valid_o), 0);
        end
        run(1, 64'h40, 0, 0, 0, 0, 1, fc, fi, fe);
        chk("post_rst_fetch_cycle", 80'(fc), 5);

        for (int it = 0; it < 40; it++) begin
            int sel, l;
            logic [63:0] a1, a2;
            sel = $urandom_range(1, 3);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3);
            a1 = ($urandom_range(0, 3) == 0) ? SIZE - 12 + 64'($urandom_range(0, 7)) : 64'($urandom_range(0, 8180));
            a2 = ($urandom_range(0, 3) == 0) ? SIZE - 12 + 64'($urandom_range(0, 7)) : 64'($urandom_range(0, 8180));
            run(sel[0], a1, sel[1], 1'($urandom), a2, {$urandom, $urandom}, l, fc, fi, fe);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
